// File: rtl/cmp_bist_pkg.sv
// Shared types and constants for the comparator self-test controller.
// Holds the FSM state type, LFSR/MISR constants and the LFSR step function.
package cmp_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_ZERO,
        ISSUE_RAND,
        ISSUE_CORNER,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam int          N_CORNER  = 4;

    // Galois step for x^32+x^22+x^2+x+1: shift right, fold the mask in on a 1 out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/cmp_bist_lfsr.sv
// 32-bit Galois LFSR that advances two steps per enable, so one enable
// yields a fresh operand pair (state, state_next).
module cmp_bist_lfsr
    import cmp_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [31:0] state,
    output logic [31:0] state_next
);

    assign state_next = lfsr_step(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (step) begin
            state <= lfsr_step(state_next);
        end
    end

endmodule

// File: rtl/cmp_bist_ctrl.sv
// Self-test driver/collector for a pair of comparators: issues operand pairs,
// samples both results after LATENCY cycles, counts ones/mismatches and builds a MISR.
module cmp_bist_ctrl
    import cmp_bist_pkg::*;
#(
    parameter int          BITS     = 32,
    parameter int          N_RANDOM = 11,
    parameter int          LATENCY  = 1,
    parameter logic [31:0] SEED     = 32'h0000_0001,
    localparam int         TOTAL    = 1 + N_RANDOM + N_CORNER,
    localparam int         CW       = $clog2(TOTAL + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    output logic            o_busy,
    output logic            o_done,
    output logic [BITS-1:0] o_arg_A,
    output logic [BITS-1:0] o_arg_B,
    output logic            o_arg_valid,
    input  logic            i_result_a,
    input  logic            i_result_b,
    output logic [CW-1:0]   o_vec_cnt,
    output logic [CW-1:0]   o_ones_cnt,
    output logic [CW-1:0]   o_mismatch_cnt,
    output logic [15:0]     o_signature,
    output state_t          o_state
);

    localparam logic [BITS-1:0] MSB = {1'b1, {(BITS-1){1'b0}}};

    state_t          state, state_nx;
    logic [CW-1:0]   idx;
    logic [CW-1:0]   corner_nx;
    logic [BITS-1:0] arg_a_nx, arg_b_nx;
    logic            issue_nx;
    logic            start_acc;
    logic            smp_valid;
    logic [31:0]     lfsr_q, lfsr_nx;

    assign start_acc = (state == IDLE) && i_start;
    assign o_state   = state;

    cmp_bist_lfsr #(.SEED(SEED)) u_lfsr (
        .clk        (i_clk),
        .rst        (i_rst),
        .load       (start_acc),
        .step       (state_nx == ISSUE_RAND),
        .state      (lfsr_q),
        .state_next (lfsr_nx)
    );

    // Next state plus the vector to present in the next-state's cycle; the
    // operand registers only change when a new vector is issued.
    always_comb begin
        state_nx  = state;
        arg_a_nx  = o_arg_A;
        arg_b_nx  = o_arg_B;
        issue_nx  = 1'b0;
        corner_nx = (state == ISSUE_CORNER) ? idx + CW'(1) : '0;
        case (state)
            IDLE:         if (i_start) state_nx = ISSUE_ZERO;
            ISSUE_ZERO:   state_nx = (N_RANDOM == 0) ? ISSUE_CORNER : ISSUE_RAND;
            ISSUE_RAND:   if (idx == CW'(N_RANDOM - 1)) state_nx = ISSUE_CORNER;
            ISSUE_CORNER: if (idx == CW'(N_CORNER - 1)) state_nx = (LATENCY == 0) ? DONE : DRAIN;
            DRAIN:        if (idx == CW'(LATENCY - 1)) state_nx = DONE;
            DONE:         state_nx = IDLE;
            default:      state_nx = IDLE;
        endcase
        case (state_nx)
            ISSUE_ZERO: begin
                issue_nx = 1'b1;
                arg_a_nx = '0;
                arg_b_nx = '0;
            end
            ISSUE_RAND: begin
                issue_nx = 1'b1;
                arg_a_nx = lfsr_q[BITS-1:0];
                arg_b_nx = lfsr_nx[BITS-1:0];
            end
            ISSUE_CORNER: begin
                issue_nx = 1'b1;
                arg_a_nx = corner_nx[1] ? MSB : '0;
                arg_b_nx = (corner_nx[1] ^ corner_nx[0]) ? MSB : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            idx         <= '0;
            o_arg_A     <= '0;
            o_arg_B     <= '0;
            o_arg_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= (state_nx != state) ? '0 : idx + CW'(1);
            o_arg_A     <= arg_a_nx;
            o_arg_B     <= arg_b_nx;
            o_arg_valid <= issue_nx;
            o_busy      <= issue_nx || (state_nx == DRAIN);
            o_done      <= (state_nx == DONE);
        end
    end

    generate
        if (LATENCY == 0) begin : g_no_pipe
            assign smp_valid = o_arg_valid;
        end else begin : g_pipe
            logic [LATENCY-1:0] vpipe;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    vpipe <= '0;
                end else begin
                    vpipe[0] <= o_arg_valid;
                    for (int i = 1; i < LATENCY; i++) vpipe[i] <= vpipe[i-1];
                end
            end
            assign smp_valid = vpipe[LATENCY-1];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_vec_cnt      <= '0;
            o_ones_cnt     <= '0;
            o_mismatch_cnt <= '0;
            o_signature    <= '0;
        end else if (start_acc) begin
            o_vec_cnt      <= '0;
            o_ones_cnt     <= '0;
            o_mismatch_cnt <= '0;
            o_signature    <= '0;
        end else if (smp_valid) begin
            o_vec_cnt      <= o_vec_cnt + CW'(1);
            o_ones_cnt     <= o_ones_cnt + CW'(i_result_a);
            o_mismatch_cnt <= o_mismatch_cnt + CW'(i_result_a ^ i_result_b);
            o_signature    <= {o_signature[14:0], 1'b0}
                            ^ (o_signature[15] ? MISR_POLY : 16'h0)
                            ^ {15'b0, i_result_a};
        end
    end

endmodule
